// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers (IF/ID, ID/EX, EX/MEM).
package pipe_pkg;

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: a valid bit plus an instruction/PC+4 payload with load and clear.
module pipe_entry #(
    parameter int                   INSTR_W   = 32,
    parameter int                   ADDR_W    = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc4_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc4_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc4_q;

    // NOTE: the payload is reset along with the valid bit so idle outputs are deterministic;
    // clear wins over load so a flush can never leak a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID register with a two-entry skid buffer: registered ready, strict FIFO order, flush.
module if_id_skid_reg
    import pipe_pkg::*;
#(
    parameter int          INSTR_W   = 32,
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc4,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc4,
    output logic [1:0]         occupancy
);

    localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

    state_e             state_q, state_d;
    logic               accept, pop;
    logic               main_load, main_from_skid, main_clear;
    logic               skid_load, skid_clear;
    logic               main_valid, skid_valid;
    logic [INSTR_W-1:0] skid_instr, main_instr_d;
    logic [ADDR_W-1:0]  skid_pc4, main_pc4_d;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        main_clear = 1'b1;
                        state_d    = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                    state_d        = ONE;
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = EMPTY;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    assign main_instr_d = main_from_skid ? skid_instr : in_instr;
    assign main_pc4_d   = main_from_skid ? skid_pc4   : in_pc4;

    pipe_entry #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NOP_INSTR(NOP_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .instr_i (main_instr_d),
        .pc4_i   (main_pc4_d),
        .valid_o (main_valid),
        .instr_o (out_instr),
        .pc4_o   (out_pc4)
    );

    pipe_entry #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NOP_INSTR(NOP_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (in_instr),
        .pc4_i   (in_pc4),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc4_o   (skid_pc4)
    );

    // The entry valid bits track the state exactly, so both handshake outputs come straight from flops.
    assign out_valid = main_valid;
    assign in_ready  = ~skid_valid;
    assign occupancy = state_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg: streaming, stall/drain, flush, reset.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    if_id_skid_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc4   (out_pc4),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic expect_state(input string tag, input logic valid, input logic ready,
                                input logic [31:0] instr, input logic [31:0] pc4,
                                input logic [1:0] occ);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, valid});
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ready});
        check({tag, ".out_instr"}, out_instr, instr);
        check({tag, ".out_pc4"},   out_pc4,   pc4);
        check({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
    endtask

    // Advance one rising edge and settle 1ns past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc4);
        in_valid = v;
        in_instr = instr;
        in_pc4   = pc4;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        tick(); tick();
        expect_state("reset", 1'b0, 1'b1, NOP, 32'h0, 2'd0);
        rst = 1'b0;

        // Streaming: each word appears one cycle after accept, occupancy stays at 1.
        out_ready = 1'b1;
        drive(1'b1, 32'h2001_0001, 32'h4); tick();
        expect_state("stream0", 1'b1, 1'b1, 32'h2001_0001, 32'h4, 2'd1);
        drive(1'b1, 32'h2002_0002, 32'h8); tick();
        expect_state("stream1", 1'b1, 1'b1, 32'h2002_0002, 32'h8, 2'd1);
        drive(1'b1, 32'h2003_0003, 32'hC); tick();
        expect_state("stream2", 1'b1, 1'b1, 32'h2003_0003, 32'hC, 2'd1);
        drive(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx); tick();
        expect_state("stream_end", 1'b0, 1'b1, NOP, 32'h0, 2'd0);

        // Stall fill: two accepts with decode stalled.
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 32'h100); tick();
        expect_state("fill1", 1'b1, 1'b1, 32'hAAAA_0001, 32'h100, 2'd1);
        drive(1'b1, 32'hAAAA_0002, 32'h104); tick();
        expect_state("fill2", 1'b1, 1'b0, 32'hAAAA_0001, 32'h100, 2'd2);
        drive(1'b1, 32'hAAAA_0003, 32'h108); tick();
        expect_state("full_hold", 1'b1, 1'b0, 32'hAAAA_0001, 32'h100, 2'd2);

        // Drain: the skid entry moves up and ready recovers the cycle after the first pop.
        drive(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        out_ready = 1'b1; tick();
        expect_state("drain1", 1'b1, 1'b1, 32'hAAAA_0002, 32'h104, 2'd1);
        tick();
        expect_state("drain2", 1'b0, 1'b1, NOP, 32'h0, 2'd0);

        // Flush in FULL with a word offered: both entries and the offered word vanish.
        out_ready = 1'b0;
        drive(1'b1, 32'hBBBB_0001, 32'h200); tick();
        drive(1'b1, 32'hBBBB_0002, 32'h204); tick();
        expect_state("pre_flush", 1'b1, 1'b0, 32'hBBBB_0001, 32'h200, 2'd2);
        flush = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 32'h208); tick();
        expect_state("flush_full", 1'b0, 1'b1, NOP, 32'h0, 2'd0);
        flush = 1'b0;
        drive(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx); tick();
        expect_state("flush_quiet", 1'b0, 1'b1, NOP, 32'h0, 2'd0);

        // Flush in ONE while accepting: the accepted word is discarded; the next one lands at N+2.
        drive(1'b1, 32'hCCCC_0001, 32'h300); tick();
        flush = 1'b1;
        drive(1'b1, 32'hCCCC_0002, 32'h304); tick();
        expect_state("flush_one", 1'b0, 1'b1, NOP, 32'h0, 2'd0);
        flush = 1'b0;
        drive(1'b1, 32'hCCCC_0003, 32'h308); tick();
        expect_state("post_flush", 1'b1, 1'b1, 32'hCCCC_0003, 32'h308, 2'd1);

        // Simultaneous accept and pop in ONE: the new word replaces main without a bubble.
        out_ready = 1'b1;
        drive(1'b1, 32'h5555_0002, 32'h404); tick();
        expect_state("acc_pop", 1'b1, 1'b1, 32'h5555_0002, 32'h404, 2'd1);

        // Reset with two entries held: everything returns to reset values, then normal flow.
        out_ready = 1'b0;
        drive(1'b1, 32'h6666_0001, 32'h500); tick();
        expect_state("pre_rst", 1'b1, 1'b0, 32'h5555_0002, 32'h404, 2'd2);
        rst = 1'b1;
        drive(1'b1, 32'h6666_0002, 32'h504); tick();
        expect_state("rst_mid", 1'b0, 1'b1, NOP, 32'h0, 2'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h1234_5678, 32'h600); tick();
        expect_state("post_rst", 1'b1, 1'b1, 32'h1234_5678, 32'h600, 2'd1);
        drive(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx); tick();
        expect_state("final_empty", 1'b0, 1'b1, NOP, 32'h0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
